// File: rtl/ps2_scanbuf_if.sv
// Keyboard event port: raw receiver bytes in, decoded key events out.
// The master side feeds bytes and pops events; the slave is the scan buffer.
interface ps2_scanbuf_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic [7:0]          ps2_data;
    logic                ps2_hit;
    logic                key_ack;
    logic                flush;
    logic [7:0]          key_code;
    logic                key_release;
    logic                key_ext;
    logic                key_ready;
    logic [DEPTH_LOG2:0] key_count;
    logic                overflow;

    modport master (
        output ps2_data, ps2_hit, key_ack, flush,
        input  key_code, key_release, key_ext, key_ready, key_count, overflow
    );

    modport slave (
        input  ps2_data, ps2_hit, key_ack, flush,
        output key_code, key_release, key_ext, key_ready, key_count, overflow
    );
endinterface

// File: rtl/ps2_scanbuf.sv
// PS/2 set-2 scancode decoder: folds E0/F0 prefixes into flags, collapses the
// Pause sequence, and queues key events in a FIFO popped by the CPU.
module ps2_scanbuf #(
    parameter int DEPTH_LOG2 = 4
) (
    input logic         clock,
    input logic         reset,
    ps2_scanbuf_if.slave bus
);
    localparam int                  DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL  = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_REL,
        ST_EXTREL,
        ST_PAUSE
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            skip_q, skip_d;
    logic                  hit_dly_q, hit_dly_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic [9:0]            mem_q [DEPTH];

    logic       strobe;
    logic       push;
    logic       pop;
    logic       wr_en;
    logic       ready;
    logic [9:0] push_entry;
    logic [9:0] head;

    // Decoder: one byte consumed per rising edge of ps2_hit.
    always_comb begin
        strobe     = bus.ps2_hit & ~hit_dly_q;
        hit_dly_d  = bus.ps2_hit;
        state_d    = state_q;
        skip_d     = skip_q;
        push       = 1'b0;
        push_entry = {2'b00, bus.ps2_data};
        if (strobe) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.ps2_data == 8'hE0) begin
                        state_d = ST_EXT;
                    end else if (bus.ps2_data == 8'hF0) begin
                        state_d = ST_REL;
                    end else if (bus.ps2_data == 8'hE1) begin
                        state_d = ST_PAUSE;
                        skip_d  = 3'd7;
                    end else begin
                        push = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (bus.ps2_data == 8'hF0) begin
                        state_d = ST_EXTREL;
                    end else if (bus.ps2_data != 8'hE0) begin
                        push       = 1'b1;
                        push_entry = {2'b10, bus.ps2_data};
                        state_d    = ST_IDLE;
                    end
                end
                ST_REL: begin
                    if (bus.ps2_data == 8'hE0) begin
                        state_d = ST_EXTREL;
                    end else if (bus.ps2_data != 8'hF0) begin
                        push       = 1'b1;
                        push_entry = {2'b01, bus.ps2_data};
                        state_d    = ST_IDLE;
                    end
                end
                ST_EXTREL: begin
                    if (bus.ps2_data != 8'hE0 && bus.ps2_data != 8'hF0) begin
                        push       = 1'b1;
                        push_entry = {2'b11, bus.ps2_data};
                        state_d    = ST_IDLE;
                    end
                end
                ST_PAUSE: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q == 3'd1) begin
                        push       = 1'b1;
                        push_entry = {2'b00, 8'hE1};
                        state_d    = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        if (bus.flush) begin
            state_d = ST_IDLE;
            skip_d  = 3'd0;
            push    = 1'b0;
        end
    end

    // FIFO bookkeeping; a pop frees a slot for a push in the same cycle.
    always_comb begin
        ready    = (count_q != '0);
        pop      = bus.key_ack & ready & ~bus.flush;
        wr_en    = push & ((count_q != FULL) | pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (bus.flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (wr_en && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !wr_en) begin
                count_d = count_q - 1'b1;
            end
            if (push && !wr_en) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            skip_q    <= 3'd0;
            hit_dly_q <= 1'b0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            skip_q    <= skip_d;
            hit_dly_q <= hit_dly_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
        end
    end

    // Storage holds no control state, so it needs no reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    assign head            = ready ? mem_q[rd_ptr_q] : 10'd0;
    assign bus.key_ext     = head[9];
    assign bus.key_release = head[8];
    assign bus.key_code    = head[7:0];
    assign bus.key_ready   = ready;
    assign bus.key_count   = count_q;
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_ps2_scanbuf.sv
// Bench for ps2_scanbuf: vector table, hand-written corner sequences and a
// randomized phase checked against a queue-based reference model.
module tb_ps2_scanbuf;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    ps2_scanbuf_if #(.DEPTH_LOG2(4)) bus ();

    ps2_scanbuf #(.DEPTH_LOG2(4)) dut (
        .clock(clk),
        .reset(rst),
        .bus  (bus.slave)
    );

    // Reference model: event queue plus prefix flags and remaining Pause bytes.
    bit [9:0] mq[$];
    bit       m_ext, m_rel, m_ovf, m_hit_prev;
    int       m_pause;

    function automatic void model_reset();
        mq.delete();
        m_ext = 0; m_rel = 0; m_ovf = 0; m_hit_prev = 0; m_pause = 0;
    endfunction

    function automatic void model_step();
        bit       strobe;
        bit       do_push;
        bit       pop;
        bit       full;
        bit [9:0] ent;
        bit [7:0] d;
        d          = bus.ps2_data;
        strobe     = bus.ps2_hit && !m_hit_prev;
        m_hit_prev = bus.ps2_hit;
        if (bus.flush) begin
            mq.delete();
            m_ovf = 0; m_ext = 0; m_rel = 0; m_pause = 0;
            return;
        end
        pop     = bus.key_ack && (mq.size() > 0);
        do_push = 0;
        ent     = '0;
        if (strobe) begin
            if (m_pause > 0) begin
                m_pause--;
                if (m_pause == 0) begin
                    do_push = 1;
                    ent     = {2'b00, 8'hE1};
                end
            end else if (d == 8'hE0) begin
                m_ext = 1;
            end else if (d == 8'hF0) begin
                m_rel = 1;
            end else if (d == 8'hE1 && !m_ext && !m_rel) begin
                m_pause = 7;
            end else begin
                do_push = 1;
                ent     = {m_ext, m_rel, d};
                m_ext   = 0;
                m_rel   = 0;
            end
        end
        full = (mq.size() == 16);
        if (pop) void'(mq.pop_front());
        if (do_push) begin
            if (full && !pop) m_ovf = 1;
            else mq.push_back(ent);
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] head_now();
        return {bus.key_ext, bus.key_release, bus.key_code};
    endfunction

    task automatic check_model(input string tag);
        check({tag, " count"}, 32'(bus.key_count), 32'(mq.size()));
        check({tag, " ready"}, 32'(bus.key_ready), 32'(mq.size() > 0));
        check({tag, " head"}, 32'(head_now()), (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
        check({tag, " overflow"}, 32'(bus.overflow), 32'(m_ovf));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.ps2_data = b;
        bus.ps2_hit  = 1'b1;
        repeat (3) tick();
        bus.ps2_hit = 1'b0;
        tick();
    endtask

    task automatic pulse_ack();
        bus.key_ack = 1'b1;
        tick();
        bus.key_ack = 1'b0;
    endtask

    typedef struct {
        bit         is_ack;
        logic [7:0] data;
        int         exp_count;
        logic [9:0] exp_head;
        bit         exp_ovf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit a, logic [7:0] d, int c, logic [9:0] h);
        vec_t v;
        v.is_ack = a; v.data = d; v.exp_count = c; v.exp_head = h; v.exp_ovf = 0;
        return v;
    endfunction

    initial begin
        bus.ps2_data = '0;
        bus.ps2_hit  = 1'b0;
        bus.key_ack  = 1'b0;
        bus.flush    = 1'b0;
        model_reset();

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset count", 32'(bus.key_count), 0);
        check("reset ready", 32'(bus.key_ready), 0);
        check("reset head", 32'(head_now()), 0);
        check("reset overflow", 32'(bus.overflow), 0);
        rst = 1'b0;
        tick();

        tbl.push_back(mk(0, 8'h1C, 1, 10'h01C));
        tbl.push_back(mk(0, 8'hF0, 1, 10'h01C));
        tbl.push_back(mk(0, 8'h1C, 2, 10'h01C));
        tbl.push_back(mk(1, 8'h00, 1, 10'h11C));
        tbl.push_back(mk(1, 8'h00, 0, 10'h000));
        tbl.push_back(mk(1, 8'h00, 0, 10'h000));
        tbl.push_back(mk(0, 8'hE0, 0, 10'h000));
        tbl.push_back(mk(0, 8'hF0, 0, 10'h000));
        tbl.push_back(mk(0, 8'h75, 1, 10'h375));
        tbl.push_back(mk(1, 8'h00, 0, 10'h000));
        tbl.push_back(mk(0, 8'hE1, 0, 10'h000));
        tbl.push_back(mk(0, 8'h14, 0, 10'h000));
        tbl.push_back(mk(0, 8'h77, 0, 10'h000));
        tbl.push_back(mk(0, 8'hE1, 0, 10'h000));
        tbl.push_back(mk(0, 8'hF0, 0, 10'h000));
        tbl.push_back(mk(0, 8'h14, 0, 10'h000));
        tbl.push_back(mk(0, 8'hF0, 0, 10'h000));
        tbl.push_back(mk(0, 8'h77, 1, 10'h0E1));
        tbl.push_back(mk(0, 8'h29, 2, 10'h0E1));
        tbl.push_back(mk(1, 8'h00, 1, 10'h029));
        tbl.push_back(mk(0, 8'hE0, 1, 10'h029));
        tbl.push_back(mk(0, 8'hE0, 1, 10'h029));
        tbl.push_back(mk(0, 8'h6B, 2, 10'h029));
        tbl.push_back(mk(1, 8'h00, 1, 10'h26B));
        tbl.push_back(mk(0, 8'hAA, 2, 10'h26B));
        tbl.push_back(mk(1, 8'h00, 1, 10'h0AA));
        tbl.push_back(mk(1, 8'h00, 0, 10'h000));

        foreach (tbl[i]) begin
            if (tbl[i].is_ack) pulse_ack();
            else send_byte(tbl[i].data);
            check($sformatf("vec%0d count", i), 32'(bus.key_count), 32'(tbl[i].exp_count));
            check($sformatf("vec%0d head", i), 32'(head_now()), 32'(tbl[i].exp_head));
            check($sformatf("vec%0d ovf", i), 32'(bus.overflow), 32'(tbl[i].exp_ovf));
        end

        // Overflow: 17 pushes into a 16-deep queue.
        for (int i = 1; i <= 17; i++) send_byte(8'(i));
        check("ovf count", 32'(bus.key_count), 16);
        check("ovf flag", 32'(bus.overflow), 1);
        check("ovf head", 32'(head_now()), 32'h001);
        for (int i = 1; i <= 16; i++) begin
            check($sformatf("drain %0d", i), 32'(head_now()), 32'(i));
            pulse_ack();
        end
        check("drained ready", 32'(bus.key_ready), 0);
        check("drained head", 32'(head_now()), 0);
        check("ovf sticky", 32'(bus.overflow), 1);
        pulse_ack();
        check("ack empty count", 32'(bus.key_count), 0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush ovf", 32'(bus.overflow), 0);

        // Full queue: push and pop in the same edge.
        for (int i = 1; i <= 16; i++) send_byte(8'(i));
        bus.ps2_data = 8'h42;
        bus.ps2_hit  = 1'b1;
        bus.key_ack  = 1'b1;
        tick();
        bus.key_ack = 1'b0;
        check("full pushpop count", 32'(bus.key_count), 16);
        check("full pushpop ovf", 32'(bus.overflow), 0);
        bus.ps2_hit = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) begin
            check($sformatf("full drain %0d", i), 32'(head_now()), (i < 15) ? 32'(i + 2) : 32'h042);
            pulse_ack();
        end
        check("full drained count", 32'(bus.key_count), 0);

        // Empty push with ack in the same cycle keeps the entry.
        bus.ps2_data = 8'h5A;
        bus.ps2_hit  = 1'b1;
        bus.key_ack  = 1'b1;
        tick();
        bus.key_ack = 1'b0;
        bus.ps2_hit = 1'b0;
        check("empty pushack count", 32'(bus.key_count), 1);
        check("empty pushack head", 32'(head_now()), 32'h05A);

        // Flush beats a simultaneous strobe and pop; hit history still tracked.
        send_byte(8'h11);
        send_byte(8'h12);
        bus.ps2_data = 8'h33;
        bus.ps2_hit  = 1'b1;
        bus.key_ack  = 1'b1;
        bus.flush    = 1'b1;
        tick();
        bus.flush   = 1'b0;
        bus.key_ack = 1'b0;
        check("flush prio count", 32'(bus.key_count), 0);
        tick();
        check("flush held hit", 32'(bus.key_count), 0);
        bus.ps2_hit = 1'b0;
        tick();
        send_byte(8'hE0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        send_byte(8'h6C);
        check("flush prefix", 32'(head_now()), 32'h06C);

        // Asynchronous reset between a prefix and its code byte.
        send_byte(8'hE0);
        #3 rst = 1'b1;
        model_reset();
        #1;
        check("async rst count", 32'(bus.key_count), 0);
        check("async rst ready", 32'(bus.key_ready), 0);
        check("async rst head", 32'(head_now()), 0);
        check("async rst ovf", 32'(bus.overflow), 0);
        #2 rst = 1'b0;
        bus.ps2_data = 8'h6B;
        bus.ps2_hit  = 1'b1;
        check("pre-strobe ready", 32'(bus.key_ready), 0);
        tick();
        check("post-strobe ready", 32'(bus.key_ready), 1);
        check("after rst head", 32'(head_now()), 32'h06B);
        tick();
        tick();
        check("one per pulse", 32'(bus.key_count), 1);
        bus.ps2_hit = 1'b0;
        tick();

        // Randomized traffic against the model.
        for (int c = 0; c < 800; c++) begin
            int r;
            if (bus.ps2_hit) begin
                if ($urandom_range(1, 0) == 0) bus.ps2_hit = 1'b0;
            end else if ($urandom_range(9, 0) < 4) begin
                r = $urandom_range(7, 0);
                bus.ps2_data = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : (r == 2) ? 8'hE1 : 8'($urandom);
                bus.ps2_hit  = 1'b1;
            end
            bus.key_ack = (c < 400) ? ($urandom_range(15, 0) == 0) : ($urandom_range(2, 0) == 0);
            bus.flush   = ($urandom_range(149, 0) == 0);
            tick();
            check_model($sformatf("rand%0d", c));
        end
        bus.flush   = 1'b0;
        bus.key_ack = 1'b0;
        bus.ps2_hit = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
